// File: rtl/ppf_commutator_if.sv
// AXI-Stream style bundle used on both sides of the PPF input commutator.
// The same interface serves the narrow sample stream and the wide frame
// stream; only the data width differs between the two instances.
interface ppf_commutator_if #(
    parameter int W = 16
) ();
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;
    logic         tlast;

    // Source side: drives data, valid and last, and observes ready.
    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    // Sink side: observes data, valid and last, and drives ready.
    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/ppf_commutator.sv
// Input commutator for the direct-input polyphase filter bank.
// Consecutive input samples are dealt across DECIM lanes, with the first
// sample of a frame landing in the top lane. A completed frame is presented
// as one wide word with a single-cycle handshake, so the whole filter bank
// shares one clock instead of using a divided branch clock.
module ppf_commutator #(
    parameter int DATA_W = 16,
    parameter int DECIM  = 8,
    parameter int PH_W   = 6
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    ppf_commutator_if.slave  s_axis,
    ppf_commutator_if.master m_axis,
    output logic [PH_W-1:0]  phase_o,
    output logic             frame_err_o
);
    localparam int              FILL_W     = (DECIM - 1) * DATA_W;
    localparam int              OUT_W      = DECIM * DATA_W;
    localparam logic [PH_W-1:0] LAST_PHASE = PH_W'(DECIM - 1);

    logic [PH_W-1:0]   r_phase;
    logic [FILL_W-1:0] r_fill;
    logic [OUT_W-1:0]  r_out;
    logic              r_valid;
    logic              r_err;

    logic              w_last_phase;
    logic              w_ready;
    logic              w_accept;
    logic              w_load;
    logic              w_misalign;

    // The only sample that can stall is the one completing a frame while the
    // previous frame is still unconsumed; every earlier phase lands in the
    // fill buffer, which is free because the pending frame already left it.
    assign w_last_phase = (r_phase == LAST_PHASE);
    assign w_ready      = rstn_i && !(w_last_phase && r_valid && !m_axis.tready);
    assign w_accept     = s_axis.tvalid && w_ready;
    assign w_load       = w_accept && w_last_phase;
    assign w_misalign   = w_accept && s_axis.tlast && !w_last_phase;

    assign s_axis.tready = w_ready;
    assign m_axis.tdata  = r_out;
    assign m_axis.tvalid = r_valid;
    assign m_axis.tlast  = 1'b1;
    assign phase_o       = r_phase;
    assign frame_err_o   = r_err;

    // Phase counter: advances per accepted sample, wraps after the last lane,
    // and restarts at zero when an early tlast forces a resync.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_phase <= '0;
        end else if (w_misalign || w_load) begin
            r_phase <= '0;
        end else if (w_accept) begin
            r_phase <= r_phase + PH_W'(1);
        end
    end

    // Fill buffer: phase k goes to lane DECIM-1-k, stored at slot lane-1
    // because lane 0 is taken straight from the input on the final sample.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_fill <= '0;
        end else if (w_accept && !w_last_phase && !w_misalign) begin
            for (int n = 1; n < DECIM; n++) begin
                if (r_phase == PH_W'(DECIM - 1 - n)) begin
                    r_fill[(n-1)*DATA_W +: DATA_W] <= s_axis.tdata;
                end
            end
        end
    end

    // Output frame register: loads the whole frame in one cycle and holds
    // data and valid steady until the downstream bank takes it.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_out   <= '0;
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_out   <= {r_fill, s_axis.tdata};
            r_valid <= 1'b1;
        end else if (m_axis.tready) begin
            r_valid <= 1'b0;
        end
    end

    // Alignment error pulse, one cycle after a tlast arrives too early.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_misalign;
        end
    end
endmodule

// File: tb/tb_ppf_commutator.sv
// Self-checking bench for the PPF input commutator. A queue-based model
// collects accepted samples into frames and tracks the single output slot;
// a second instance exercises the smallest legal decimation.
module tb_ppf_commutator;
    logic clk = 1'b0;
    logic rstn;
    logic rstn2;

    always #5 clk = ~clk;

    ppf_commutator_if #(.W(16))  sIf ();
    ppf_commutator_if #(.W(128)) mIf ();
    ppf_commutator_if #(.W(12))  sIf2 ();
    ppf_commutator_if #(.W(24))  mIf2 ();

    logic [5:0] phase;
    logic       frameErr;
    logic [0:0] phase2;
    logic       frameErr2;

    ppf_commutator #(.DATA_W(16), .DECIM(8), .PH_W(6)) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .s_axis      (sIf),
        .m_axis      (mIf),
        .phase_o     (phase),
        .frame_err_o (frameErr)
    );

    ppf_commutator #(.DATA_W(12), .DECIM(2), .PH_W(1)) dut2 (
        .clk_i       (clk),
        .rstn_i      (rstn2),
        .s_axis      (sIf2),
        .m_axis      (mIf2),
        .phase_o     (phase2),
        .frame_err_o (frameErr2)
    );

    int checks = 0;
    int failures = 0;

    // Reference model state: samples of the frame in progress plus the one
    // output slot the downstream bank reads from.
    logic [15:0]  partial[$];
    logic         modelValid = 1'b0;
    logic [127:0] modelData = '0;
    logic         modelErr = 1'b0;

    logic         obsTready, obsValid, obsErr;
    logic [127:0] obsData;
    logic [5:0]   obsPhase;
    logic         expTready, expValid, expErr;
    logic [127:0] expData;
    logic [5:0]   expPhase;
    logic         accepted, fired;

    // Frame whose top lane holds base and whose lane 0 holds base+7.
    function automatic logic [127:0] buildFrame(input int base);
        logic [127:0] f;
        for (int n = 0; n < 8; n++) f[n*16 +: 16] = 16'(base + 7 - n);
        return f;
    endfunction

    // One clock of stimulus on the main instance: drive at the falling edge,
    // sample shortly after, then advance the model across the next rising edge.
    task automatic driveMain(input logic rn, input logic v, input logic [15:0] d,
                             input logic l, input logic mr);
        logic [127:0] frame;
        @(negedge clk);
        rstn        = rn;
        sIf.tvalid  = v;
        sIf.tdata   = d;
        sIf.tlast   = l;
        mIf.tready  = mr;
        #1;
        obsTready = sIf.tready;
        obsValid  = mIf.tvalid;
        obsData   = mIf.tdata;
        obsPhase  = phase;
        obsErr    = frameErr;
        expPhase  = 6'(partial.size());
        expValid  = modelValid;
        expData   = modelData;
        expErr    = modelErr;
        expTready = rn && !(partial.size() == 7 && modelValid && !mr);
        accepted  = v && expTready;
        fired     = modelValid && mr;
        if (!rn) begin
            partial.delete();
            modelValid = 1'b0;
            modelData  = '0;
            modelErr   = 1'b0;
        end else begin
            modelErr = 1'b0;
            if (fired) modelValid = 1'b0;
            if (accepted) begin
                if (l && partial.size() != 7) begin
                    partial.delete();
                    modelErr = 1'b1;
                end else begin
                    partial.push_back(d);
                    if (partial.size() == 8) begin
                        for (int n = 0; n < 8; n++) frame[n*16 +: 16] = partial[7-n];
                        modelData  = frame;
                        modelValid = 1'b1;
                        partial.delete();
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            driveMain(1'b0, 1'b1, 16'hABCD, 1'b0, 1'b1);
            checks++;
            if (obsTready !== 1'b0) begin
                failures++; $display("[TB] FAIL reset_tready: got %b expected 0", obsTready);
            end
            if (k > 0) begin
                checks++;
                if (obsPhase !== 6'd0 || obsValid !== 1'b0 || obsErr !== 1'b0 || obsData !== 128'd0) begin
                    failures++;
                    $display("[TB] FAIL reset_state: got phase=%0d valid=%b err=%b data=%h expected 0/0/0/0",
                             obsPhase, obsValid, obsErr, obsData);
                end
            end
        end
    endtask

    task automatic test_count_stream();
        int firstValid = -1;
        for (int k = 0; k < 25; k++) begin
            driveMain(1'b1, k < 24, 16'(k), (k % 8) == 7, 1'b1);
            checks++;
            if (obsPhase !== expPhase) begin
                failures++; $display("[TB] FAIL count_phase k=%0d: got %0d expected %0d", k, obsPhase, expPhase);
            end
            checks++;
            if (obsTready !== 1'b1 || obsErr !== 1'b0) begin
                failures++; $display("[TB] FAIL count_ready_err k=%0d: got %b/%b expected 1/0", k, obsTready, obsErr);
            end
            checks++;
            if (obsValid !== expValid) begin
                failures++; $display("[TB] FAIL count_valid k=%0d: got %b expected %b", k, obsValid, expValid);
            end
            if (expValid) begin
                checks++;
                if (obsData !== expData) begin
                    failures++; $display("[TB] FAIL count_data k=%0d: got %h expected %h", k, obsData, expData);
                end
            end
            if (obsValid === 1'b1 && firstValid < 0) firstValid = k;
            if (k == 8) begin
                checks++;
                if (obsData !== 128'h0000_0001_0002_0003_0004_0005_0006_0007) begin
                    failures++; $display("[TB] FAIL count_first_frame: got %h expected 0000..0007", obsData);
                end
            end
            if (k == 16) begin
                checks++;
                if (obsData[127:112] !== 16'd8) begin
                    failures++; $display("[TB] FAIL count_second_lane7: got %0d expected 8", obsData[127:112]);
                end
            end
        end
        checks++;
        if (firstValid != 8) begin
            failures++; $display("[TB] FAIL count_latency: got cycle %0d expected 8", firstValid);
        end
    endtask

    task automatic test_backpressure();
        int next = 108;
        logic [127:0] held;
        held = buildFrame(100);
        for (int k = 0; k < 8; k++) driveMain(1'b1, 1'b1, 16'(100 + k), k == 7, 1'b1);
        for (int k = 0; k < 12; k++) begin
            driveMain(1'b1, 1'b1, 16'(next), next == 115, 1'b0);
            checks++;
            if (obsTready !== expTready || obsTready !== (obsPhase != 6'd7)) begin
                failures++;
                $display("[TB] FAIL bp_tready k=%0d phase=%0d: got %b expected %b", k, obsPhase, obsTready, expTready);
            end
            checks++;
            if (obsValid !== 1'b1 || obsData !== held) begin
                failures++; $display("[TB] FAIL bp_hold k=%0d: got %b/%h expected 1/%h", k, obsValid, obsData, held);
            end
            if (accepted) next++;
        end
        checks++;
        if (next != 115) begin
            failures++; $display("[TB] FAIL bp_accepted: got next=%0d expected 115", next);
        end
        driveMain(1'b1, 1'b1, 16'(115), 1'b1, 1'b1);
        checks++;
        if (obsTready !== 1'b1 || obsData !== held) begin
            failures++; $display("[TB] FAIL bp_release: got %b/%h expected 1/%h", obsTready, obsData, held);
        end
        driveMain(1'b1, 1'b0, 16'd0, 1'b0, 1'b1);
        checks++;
        if (obsValid !== 1'b1 || obsData !== buildFrame(108)) begin
            failures++; $display("[TB] FAIL bp_second_frame: got %b/%h expected 1/%h", obsValid, obsData, buildFrame(108));
        end
        driveMain(1'b1, 1'b0, 16'd0, 1'b0, 1'b1);
        checks++;
        if (obsValid !== 1'b0) begin
            failures++; $display("[TB] FAIL bp_drained: got %b expected 0", obsValid);
        end
    endtask

    task automatic test_misaligned_tlast();
        for (int k = 0; k < 5; k++) begin
            driveMain(1'b1, 1'b1, 16'(300 + k), k == 4, 1'b1);
            checks++;
            if (obsValid !== 1'b0 || obsErr !== 1'b0) begin
                failures++; $display("[TB] FAIL mis_pre k=%0d: got %b/%b expected 0/0", k, obsValid, obsErr);
            end
        end
        driveMain(1'b1, 1'b0, 16'd0, 1'b0, 1'b1);
        checks++;
        if (obsErr !== 1'b1 || obsPhase !== 6'd0 || obsValid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mis_pulse: got err=%b phase=%0d valid=%b expected 1/0/0", obsErr, obsPhase, obsValid);
        end
        driveMain(1'b1, 1'b0, 16'd0, 1'b0, 1'b1);
        checks++;
        if (obsErr !== 1'b0) begin
            failures++; $display("[TB] FAIL mis_pulse_width: got %b expected 0", obsErr);
        end
        for (int k = 0; k < 8; k++) begin
            driveMain(1'b1, 1'b1, 16'(310 + k), k == 7, 1'b1);
            checks++;
            if (obsValid !== 1'b0 || obsErr !== 1'b0 || obsPhase !== 6'(k)) begin
                failures++;
                $display("[TB] FAIL mis_clean k=%0d: got valid=%b err=%b phase=%0d expected 0/0/%0d",
                         k, obsValid, obsErr, obsPhase, k);
            end
        end
        driveMain(1'b1, 1'b0, 16'd0, 1'b0, 1'b1);
        checks++;
        if (obsValid !== 1'b1 || obsData !== buildFrame(310)) begin
            failures++; $display("[TB] FAIL mis_frame: got %b/%h expected 1/%h", obsValid, obsData, buildFrame(310));
        end
    endtask

    task automatic test_midframe_reset();
        for (int k = 0; k < 8; k++) driveMain(1'b1, 1'b1, 16'(400 + k), k == 7, 1'b0);
        for (int k = 0; k < 3; k++) begin
            driveMain(1'b1, 1'b1, 16'(408 + k), 1'b0, 1'b0);
            checks++;
            if (obsTready !== 1'b1 || obsValid !== 1'b1) begin
                failures++; $display("[TB] FAIL rst_pending k=%0d: got %b/%b expected 1/1", k, obsTready, obsValid);
            end
        end
        driveMain(1'b0, 1'b1, 16'(411), 1'b0, 1'b0);
        checks++;
        if (obsTready !== 1'b0 || obsPhase !== 6'd3) begin
            failures++; $display("[TB] FAIL rst_assert: got tready=%b phase=%0d expected 0/3", obsTready, obsPhase);
        end
        driveMain(1'b1, 1'b0, 16'd0, 1'b0, 1'b1);
        checks++;
        if (obsValid !== 1'b0 || obsPhase !== 6'd0 || obsData !== 128'd0) begin
            failures++;
            $display("[TB] FAIL rst_cleared: got valid=%b phase=%0d data=%h expected 0/0/0", obsValid, obsPhase, obsData);
        end
        for (int k = 0; k < 8; k++) driveMain(1'b1, 1'b1, 16'(500 + k), k == 7, 1'b1);
        driveMain(1'b1, 1'b0, 16'd0, 1'b0, 1'b1);
        checks++;
        if (obsValid !== 1'b1 || obsData !== buildFrame(500)) begin
            failures++; $display("[TB] FAIL rst_post_frame: got %b/%h expected 1/%h", obsValid, obsData, buildFrame(500));
        end
    endtask

    task automatic test_random_burst();
        logic [15:0] seqNext = 16'd1000;
        int lastBase = 992;
        int framesSeen = 0;
        int totalAcc = 0;
        int base;
        logic v, mr, l;
        for (int k = 0; k < 800; k++) begin
            v  = 1'($urandom_range(0, 1));
            mr = 1'($urandom_range(0, 1));
            l  = (partial.size() == 7) && ($urandom_range(0, 3) != 0);
            driveMain(1'b1, v, seqNext, l, mr);
            checks++;
            if (obsPhase !== expPhase || obsTready !== expTready || obsErr !== 1'b0) begin
                failures++;
                $display("[TB] FAIL rnd_ctrl k=%0d: got phase=%0d tready=%b err=%b expected %0d/%b/0",
                         k, obsPhase, obsTready, obsErr, expPhase, expTready);
            end
            checks++;
            if (obsValid !== expValid) begin
                failures++; $display("[TB] FAIL rnd_valid k=%0d: got %b expected %b", k, obsValid, expValid);
            end
            if (expValid) begin
                checks++;
                if (obsData !== expData) begin
                    failures++; $display("[TB] FAIL rnd_data k=%0d: got %h expected %h", k, obsData, expData);
                end
            end
            if (fired) begin
                base = int'(obsData[127:112]);
                checks++;
                if (obsData !== buildFrame(base) || base != lastBase + 8) begin
                    failures++;
                    $display("[TB] FAIL rnd_sequence k=%0d: got base %0d data %h expected base %0d",
                             k, base, obsData, lastBase + 8);
                end
                lastBase = base;
                framesSeen++;
            end
            if (accepted) begin
                seqNext++;
                totalAcc++;
            end
        end
        for (int k = 0; k < 3; k++) begin
            driveMain(1'b1, 1'b0, 16'd0, 1'b0, 1'b1);
            if (fired) framesSeen++;
        end
        checks++;
        if (framesSeen * 8 != totalAcc - partial.size()) begin
            failures++;
            $display("[TB] FAIL rnd_count: got %0d frames expected %0d", framesSeen, (totalAcc - partial.size()) / 8);
        end
    endtask

    task automatic test_boundary_decim2();
        logic [11:0] a, b;
        @(negedge clk);
        rstn2 = 1'b0; sIf2.tvalid = 1'b0; sIf2.tlast = 1'b0; mIf2.tready = 1'b1;
        #1;
        checks++;
        if (sIf2.tready !== 1'b0) begin
            failures++; $display("[TB] FAIL d2_reset_tready: got %b expected 0", sIf2.tready);
        end
        @(negedge clk);
        #1;
        checks++;
        if (phase2 !== 1'b0 || mIf2.tvalid !== 1'b0 || mIf2.tdata !== 24'd0) begin
            failures++; $display("[TB] FAIL d2_reset_state: got %b/%b/%h expected 0/0/0", phase2, mIf2.tvalid, mIf2.tdata);
        end
        for (int p = 0; p < 3; p++) begin
            a = (p == 0) ? 12'hFFF : 12'($urandom);
            b = (p == 0) ? 12'h800 : 12'($urandom);
            @(negedge clk);
            rstn2 = 1'b1; sIf2.tvalid = 1'b1; sIf2.tdata = a; sIf2.tlast = 1'b0;
            #1;
            checks++;
            if (phase2 !== 1'b0 || sIf2.tready !== 1'b1) begin
                failures++; $display("[TB] FAIL d2_phase0 p=%0d: got %b/%b expected 0/1", p, phase2, sIf2.tready);
            end
            @(negedge clk);
            sIf2.tdata = b; sIf2.tlast = 1'b1;
            #1;
            checks++;
            if (phase2 !== 1'b1) begin
                failures++; $display("[TB] FAIL d2_phase1 p=%0d: got %b expected 1", p, phase2);
            end
            @(negedge clk);
            sIf2.tvalid = 1'b0; sIf2.tlast = 1'b0;
            #1;
            checks++;
            if (mIf2.tvalid !== 1'b1 || mIf2.tdata !== {a, b} || phase2 !== 1'b0 || frameErr2 !== 1'b0) begin
                failures++;
                $display("[TB] FAIL d2_frame p=%0d: got %b/%h phase=%b err=%b expected 1/%h phase=0 err=0",
                         p, mIf2.tvalid, mIf2.tdata, phase2, frameErr2, {a, b});
            end
        end
    endtask

    // Run every scenario in order on the shared clock, then report.
    initial begin
        rstn = 1'b0; rstn2 = 1'b0;
        sIf.tvalid = 1'b0; sIf.tdata = '0; sIf.tlast = 1'b0; mIf.tready = 1'b0;
        sIf2.tvalid = 1'b0; sIf2.tdata = '0; sIf2.tlast = 1'b0; mIf2.tready = 1'b0;
        $display("[TB] starting ppf_commutator bench");
        test_reset();
        test_count_stream();
        test_backpressure();
        test_misaligned_tlast();
        test_midframe_reset();
        test_random_burst();
        test_boundary_decim2();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ppf_commutator.md
# ppf_commutator

Input commutator for the direct-input polyphase filter bank (PPF). It accepts one AXI-Stream sample per cycle and deals consecutive samples across DECIM polyphase lanes. Each complete frame is presented as one parallel word to the FIR branch bank. A single-cycle frame handshake replaces the divided branch clock, so the whole PPF runs on one clock.

## Interface
- DATA_W, 16, sample width in bits.
- DECIM, 8, decimation ratio and number of lanes; legal range 2..64.
- PH_W, 6, phase counter width; must satisfy 2^PH_W ≥ DECIM.

- clk_i  in  1  single clock for the block.
- rstn_i  in  1  reset; synchronous, active-low.
- s_axis_tdata  in  DATA_W  input sample, two's complement.
- s_axis_tvalid  in  1  input sample valid.
- s_axis_tready  out  1  block can accept a sample.
- s_axis_tlast  in  1  marks the last sample of a frame; used for alignment check and resync.
- m_axis_tdata  out  DATA_W*DECIM  parallel frame; lane n occupies bits [n*DATA_W +: DATA_W].
- m_axis_tvalid  out  1  frame valid.
- m_axis_tready  in  1  FIR bank accepts the frame.
- phase_o  out  PH_W  index of the next input sample within the frame (0..DECIM-1).
- frame_err_o  out  1  one-cycle pulse on a misaligned tlast.

## Operation
- Accept: an input sample is accepted when s_axis_tvalid && s_axis_tready.
- Phase counter:
  - Increments on each accepted sample.
  - Wraps from DECIM-1 to 0.
  - Holds when no sample is accepted.
- Lane mapping: the sample accepted at phase k is written to lane DECIM-1-k. The first sample of a frame goes to the top lane; the last goes to lane 0.
- Fill buffer: (DECIM-1)*DATA_W register holding phases 0..DECIM-2 of the frame in progress.
- Output register:
  - Loaded when the phase-(DECIM-1) sample is accepted.
  - Takes the whole fill buffer plus the incoming sample in one cycle.
  - m_axis_tvalid is set on that load.
- Output handshake:
  - m_axis_tvalid falls on a cycle with m_axis_tready=1 and no new load.
  - A load in the same cycle as a consumed frame keeps m_axis_tvalid=1 with the new data.
- Backpressure: s_axis_tready = rstn_i && !(phase==DECIM-1 && m_axis_tvalid && !m_axis_tready).
  - Backpressure applies only at the frame-completing sample.
  - Phases 0..DECIM-2 are always accepted, so the fill buffer is never overwritten while a frame is pending.
- m_axis_tdata and m_axis_tvalid are stable while m_axis_tvalid && !m_axis_tready (AXI rule).
- tlast alignment:
  - tlast on an accepted sample at phase DECIM-1: normal; no action.
  - tlast on an accepted sample at phase ≠ DECIM-1: the partial frame is discarded (no output load). Phase resets to 0 on the next cycle, and frame_err_o pulses for one cycle.
  - Missing tlast at phase DECIM-1 is not an error; the frame is emitted normally.
- Arithmetic: no arithmetic on data; samples are passed bit-exact.

## Timing
- Reset, while rstn_i=0 at a clk_i edge:
  - phase_o=0, m_axis_tvalid=0, m_axis_tdata=0, frame_err_o=0; fill buffer cleared.
  - s_axis_tready=0 combinationally while rstn_i=0.
- Reset mid-frame discards the fill buffer and any pending output frame; no partial frame is ever emitted.
- Latency: m_axis_tvalid=1 on the cycle after the last sample of the frame is accepted.
- Throughput: one sample per cycle sustained with m_axis_tready=1; one frame every DECIM cycles.
- frame_err_o is asserted in the cycle after the offending tlast is accepted, for exactly one cycle.
- phase_o is registered and reflects accepted samples up to the previous edge.

## Test plan
- Continuous count stream, DECIM=8, inputs 0,1,2,… with m_axis_tready=1:
  - First frame at cycle 9 has lane 7=0 … lane 0=7; the next frame arrives 8 cycles later with lane 7=8.
  - frame_err_o stays 0.
- Backpressure with m_axis_tready=0 after the first frame:
  - s_axis_tready drops only at phase 7 of the second frame; phases 0..6 are still accepted.
  - Raising m_axis_tready accepts sample 15 in that cycle; the frame 8..15 appears the next cycle.
  - Frame 0..7 is held stable until consumed.
- Misaligned tlast on the 5th sample (phase 4):
  - frame_err_o pulses once and no frame is emitted.
  - The next 8 samples form a clean frame; phase_o returns 0 after the pulse.
- Reset mid-frame: assert rstn_i=0 at phase 3 with a pending output frame.
  - Next edge: m_axis_tvalid=0, phase_o=0, m_axis_tdata=0.
  - The first frame after release contains only post-reset samples.
- Bursty input, random s_axis_tvalid (50%) and random m_axis_tready:
  - Scoreboard shows every frame equals 8 consecutive accepted samples in reversed lane order.
  - No loss or duplication; AXI stability holds on both ports.
- Boundary DECIM=2, DATA_W=12, inputs 0xFFF, 0x800:
  - Frame shows lane 1=0xFFF, lane 0=0x800 bit-exact; phase_o toggles 0/1.
